banco_registradores_parametrizado: RTL and testbench

//  Parametrised register file for the MIPS datapath: 2 registered read ports, 1 write port.

---
 rtl/mips_pkg.sv | 9 +
 rtl/regfile_scoreboard.sv | 30 +++
 rtl/banco_registradores_parametrizado.sv | 75 +++++++
 tb/tb_banco_registradores_parametrizado.sv | 96 +++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared register-file defaults and constants
package mips_pkg;
  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int ADDR_W_DEF   = $clog2(NUM_REGS_DEF);
  localparam int IMM_W_DEF    = 16;
  localparam int REG_ZERO     = 0;
  localparam int FUNCT_W      = 6;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: one pending bit per register, set/clear plus two lookups
module regfile_scoreboard
  import mips_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] look_addr1,
  input  logic [ADDR_W-1:0] look_addr2,
  output logic              look_pend1,
  output logic              look_pend2
);
  logic [NUM_REGS-1:0] r_pend;
  // set after clear: a new load issued alongside a writeback stays in flight
  always_ff @(posedge clk) begin
    if (!rst_n) r_pend <= '0;
    else begin
      if (clr_en) r_pend[clr_addr] <= 1'b0;
      if (set_en) r_pend[set_addr] <= 1'b1;
    end
  end
  assign look_pend1 = r_pend[look_addr1];
  assign look_pend2 = r_pend[look_addr2];
endmodule

// File: rtl/banco_registradores_parametrizado.sv
// banco_registradores_parametrizado: 2R/1W register file with pending-load scoreboard and imm extender
// REGFILE_BYPASS_EN selects write-first reads; undefined gives read-first.
module banco_registradores_parametrizado
  import mips_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int IMM_W    = IMM_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  rd_addr1,
  input  logic [ADDR_W-1:0]  rd_addr2,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               pend_set,
  input  logic [ADDR_W-1:0]  pend_addr,
  input  logic [IMM_W-1:0]   imm_in,
  input  logic               imm_sign,
  output logic [DATA_W-1:0]  rd_data1,
  output logic [DATA_W-1:0]  rd_data2,
  output logic               rd_pend1,
  output logic               rd_pend2,
  output logic [DATA_W-1:0]  imm_out,
  output logic [FUNCT_W-1:0] funct
);
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);
  logic [DATA_W-1:0] r_mem [NUM_REGS];
  logic w_we, w_set, w_pend1, w_pend2, w_byp1, w_byp2;
  logic [DATA_W-1:0] w_d1, w_d2;
  assign w_we  = wr_en && wr_addr != ZERO;
  assign w_set = pend_set && pend_addr != ZERO;
`ifdef REGFILE_BYPASS_EN
  assign w_byp1 = w_we && wr_addr == rd_addr1;
  assign w_byp2 = w_we && wr_addr == rd_addr2;
`else
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
`endif
  regfile_scoreboard #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_en     (w_set),
    .set_addr   (pend_addr),
    .clr_en     (w_we),
    .clr_addr   (wr_addr),
    .look_addr1 (rd_addr1),
    .look_addr2 (rd_addr2),
    .look_pend1 (w_pend1),
    .look_pend2 (w_pend2)
  );
  assign w_d1 = rd_addr1 == ZERO ? '0 : w_byp1 ? wr_data : r_mem[rd_addr1];
  assign w_d2 = rd_addr2 == ZERO ? '0 : w_byp2 ? wr_data : r_mem[rd_addr2];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
      rd_data1 <= '0;
      rd_data2 <= '0;
      rd_pend1 <= 1'b0;
      rd_pend2 <= 1'b0;
      imm_out  <= '0;
      funct    <= '0;
    end else begin
      if (w_we) r_mem[wr_addr] <= wr_data;
      rd_data1 <= w_d1;
      rd_data2 <= w_d2;
      rd_pend1 <= w_pend1 && !w_byp1;
      rd_pend2 <= w_pend2 && !w_byp2;
      imm_out  <= {{(DATA_W-IMM_W){imm_sign & imm_in[IMM_W-1]}}, imm_in};
      funct    <= imm_in[FUNCT_W-1:0];
    end
  end
endmodule

// File: tb/tb_banco_registradores_parametrizado.sv
// tb_banco_registradores_parametrizado: table-driven check of reads, writes, r0, scoreboard and immediates
module tb_banco_registradores_parametrizado;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 0, rst_n, wr_en, pend_set, imm_sign, rd_pend1, rd_pend2;
  logic [4:0] rd_addr1, rd_addr2, wr_addr, pend_addr;
  logic [31:0] wr_data, rd_data1, rd_data2, imm_out;
  logic [15:0] imm_in;
  logic [5:0] funct;
  int total = 0, passed = 0;

  typedef struct {
    logic rst_n; logic [4:0] ra1, ra2; logic we; logic [4:0] wa; logic [31:0] wd;
    logic ps; logic [4:0] pa; logic [15:0] imm; logic sgn;
    logic [31:0] d1, d2; logic p1, p2; logic [31:0] io; logic [5:0] fn;
  } vec_t;
  vec_t q[$];

  always #5 clk = ~clk;

  banco_registradores_parametrizado dut (
    .clk(clk), .rst_n(rst_n), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pend_set(pend_set), .pend_addr(pend_addr), .imm_in(imm_in), .imm_sign(imm_sign),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .rd_pend1(rd_pend1), .rd_pend2(rd_pend2),
    .imm_out(imm_out), .funct(funct)
  );

  function automatic vec_t mk(logic r, logic [4:0] ra1, ra2, logic we, logic [4:0] wa,
                              logic [31:0] wd, logic ps, logic [4:0] pa, logic [15:0] imm,
                              logic sgn, logic [31:0] d1, d2, logic p1, p2,
                              logic [31:0] io, logic [5:0] fn);
    vec_t v;
    v.rst_n = r; v.ra1 = ra1; v.ra2 = ra2; v.we = we; v.wa = wa; v.wd = wd;
    v.ps = ps; v.pa = pa; v.imm = imm; v.sgn = sgn;
    v.d1 = d1; v.d2 = d2; v.p1 = p1; v.p2 = p2; v.io = io; v.fn = fn;
    return v;
  endfunction

  task automatic chk(string n, int idx, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s[%0d]: got 0x%08h expected 0x%08h", n, idx, act, exp);
    else passed++;
  endtask

  task automatic run(vec_t v, int idx);
    rst_n = v.rst_n; rd_addr1 = v.ra1; rd_addr2 = v.ra2; wr_en = v.we; wr_addr = v.wa;
    wr_data = v.wd; pend_set = v.ps; pend_addr = v.pa; imm_in = v.imm; imm_sign = v.sgn;
    @(posedge clk);
    @(negedge clk);
    chk("rd_data1", idx, rd_data1, v.d1);
    chk("rd_data2", idx, rd_data2, v.d2);
    chk("rd_pend1", idx, 32'(rd_pend1), 32'(v.p1));
    chk("rd_pend2", idx, 32'(rd_pend2), 32'(v.p2));
    chk("imm_out", idx, imm_out, v.io);
    chk("funct", idx, 32'(funct), 32'(v.fn));
  endtask

  initial begin
    // reset overrides a write and a pend_set in the same cycle
    q.push_back(mk(0, 5, 31, 1, 5, 32'hFFFF_FFFF, 1, 5, 16'h8001, 1, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(0, 5, 31, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(1, 5, 31, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(1, 0, 0, 1, 7, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0));
    q.push_back(mk(1, 0, 0, 1, 0, 32'h1234, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(1, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 0, 0, 0, 0));
    q.push_back(mk(1, 9, 7, 1, 9, 32'h55, 0, 0, 0, 0, BYP ? 32'h55 : 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 0));
    q.push_back(mk(1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 32'h55, 0, 0, 0, 0, 0));
    q.push_back(mk(1, 12, 0, 0, 0, 0, 1, 12, 0, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(1, 12, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    q.push_back(mk(1, 12, 0, 1, 12, 32'h3, 0, 0, 0, 0, BYP ? 32'h3 : 32'h0, 0, !BYP, 0, 0, 0));
    q.push_back(mk(1, 12, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3, 0, 0, 0, 0, 0));
    q.push_back(mk(1, 12, 0, 1, 12, 32'h4, 1, 12, 0, 0, BYP ? 32'h4 : 32'h3, 0, 0, 0, 0, 0));
    q.push_back(mk(1, 12, 0, 0, 0, 0, 0, 0, 0, 0, 32'h4, 0, 1, 0, 0, 0));
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 16'h8001, 1, 0, 0, 0, 0, 32'hFFFF_8001, 6'h01));
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 16'h8001, 0, 0, 0, 0, 0, 32'h0000_8001, 6'h01));
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 16'h7FC5, 1, 0, 0, 0, 0, 32'h0000_7FC5, 6'h05));
    rst_n = 0; rd_addr1 = 0; rd_addr2 = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
    pend_set = 0; pend_addr = 0; imm_in = 0; imm_sign = 0;
    @(negedge clk);
    foreach (q[i]) run(q[i], i);
    // mid-run reset must wipe stored data and the pending bit left on r12
    run(mk(0, 7, 12, 1, 31, 32'hA5A5_A5A5, 1, 31, 16'hFFFF, 1, 0, 0, 0, 0, 0, 0), 100);
    run(mk(1, 7, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 101);
    run(mk(1, 31, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 102);
    // port 2 write/read and pending on the top register index
    run(mk(1, 0, 31, 1, 31, 32'h8765_4321, 1, 31, 0, 0, 0, BYP ? 32'h8765_4321 : 32'h0, 0, 0, 0, 0), 103);
    run(mk(1, 0, 31, 0, 0, 0, 0, 0, 0, 0, 0, 32'h8765_4321, 0, 1, 0, 0), 104);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
